// File: rtl/time_display_scanner.sv
// rtl/time_display_scanner.sv - samples the watch time registers and scans them onto a 6-digit 7-segment display
//
// Purpose:
//   The five time registers are clocked by ripple carries, so they are
//   asynchronous to clk. This block synchronises them and accepts a snapshot
//   only when two consecutive synchronised samples agree. It decodes the
//   thermometer and one-hot codes to decimal digits and multiplexes those
//   digits onto a common-cathode 7-segment display. Any illegal code blanks
//   the time: every digit shows a dash and err is raised.
//
// Parameters:
//   SCAN_DIV    - clk cycles each digit stays enabled (2..65535)
//
// Ports:
//   clk         - in  1   free-running system clock
//   reset       - in  1   asynchronous, active-high reset
//   sec_fine    - in  4   seconds-fine thermometer code (0..4)
//   sec_coarse  - in  12  seconds-coarse one-hot code (bit 11-k -> k)
//   mins_fine   - in  4   minutes-fine thermometer code (0..4)
//   mins_coarse - in  12  minutes-coarse one-hot code (bit 11-k -> k)
//   hours       - in  12  hours one-hot code (index 0 displays as 12)
//   seg         - out 7   segment drive {g,f,e,d,c,b,a}, active-high
//   dig         - out 6   one-hot digit enable, dig[0] = seconds ones
//   dp          - out 1   separator dot, lit on digits 2 and 4
//   err         - out 1   current snapshot holds an illegal code

module time_display_scanner #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  sec_fine,
    input  logic [11:0] sec_coarse,
    input  logic [3:0]  mins_fine,
    input  logic [11:0] mins_coarse,
    input  logic [11:0] hours,
    output logic [6:0]  seg,
    output logic [5:0]  dig,
    output logic        dp,
    output logic        err
);

    localparam int unsigned IN_W  = 44;
    localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    // Internal digit code that never comes out of the BCD split; used for the
    // suppressed leading zero of the hours.
    localparam logic [3:0] DIGIT_BLANK = 4'hF;
    localparam logic [6:0] SEG_DASH    = 7'b1000000;
    localparam logic [6:0] SEG_OFF     = 7'b0000000;

    // ------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------

    // Thermometer fills from the MSB: 1000 = 1, 1100 = 2, ...
    function automatic logic fine_legal(input logic [3:0] code);
        logic ok;
        case (code)
            4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111: ok = 1'b1;
            default:                                     ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] fine_value(input logic [3:0] code);
        logic [2:0] v;
        case (code)
            4'b1000: v = 3'd1;
            4'b1100: v = 3'd2;
            4'b1110: v = 3'd3;
            4'b1111: v = 3'd4;
            default: v = 3'd0;
        endcase
        return v;
    endfunction

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    function automatic logic coarse_legal(input logic [11:0] code);
        return (code != 12'd0) && ((code & (code - 12'd1)) == 12'd0);
    endfunction

    // Bit (11-k) set gives index k. Only meaningful when the code is legal.
    function automatic logic [3:0] coarse_index(input logic [11:0] code);
        logic [3:0] idx;
        idx = 4'd0;
        for (int k = 0; k < 12; k++) begin
            if (code[11-k]) begin
                idx = 4'(k);
            end
        end
        return idx;
    endfunction

    // Tens/ones of a 0..59 value by constant comparison, no divider.
    function automatic logic [7:0] bcd_split(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] rem;
        if      (v >= 6'd50) tens = 4'd5;
        else if (v >= 6'd40) tens = 4'd4;
        else if (v >= 6'd30) tens = 4'd3;
        else if (v >= 6'd20) tens = 4'd2;
        else if (v >= 6'd10) tens = 4'd1;
        else                 tens = 4'd0;
        rem = v - ({2'b00, tens} * 6'd10);
        return {tens, rem[3:0]};
    endfunction

    function automatic logic [6:0] font(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Synchroniser and coherence filter
    // ------------------------------------------------------------------
    logic [IN_W-1:0] in_bus;
    logic [IN_W-1:0] s1_q, s2_q, s3_q, snap_q;

    assign in_bus = {hours, mins_coarse, mins_fine, sec_coarse, sec_fine};

    // A ripple carry settles over several flops; two equal consecutive
    // synchronised samples mean the counters were quiet for a full cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            snap_q <= '0;
        end else begin
            s1_q <= in_bus;
            s2_q <= s1_q;
            s3_q <= s2_q;
            if (s2_q == s3_q) begin
                snap_q <= s2_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Snapshot decode into six digits
    // ------------------------------------------------------------------
    logic [3:0]  snap_sf, snap_mf;
    logic [11:0] snap_sc, snap_mc, snap_h;
    logic [3:0]  k_sc, k_mc, k_h;
    logic [5:0]  sec_val, min_val;
    logic [3:0]  hr_val;
    logic [7:0]  sec_bcd, min_bcd;
    logic        err_d;
    logic [3:0]  digit_d [6];

    assign snap_sf = snap_q[3:0];
    assign snap_sc = snap_q[15:4];
    assign snap_mf = snap_q[19:16];
    assign snap_mc = snap_q[31:20];
    assign snap_h  = snap_q[43:32];

    always_comb begin
        k_sc    = coarse_index(snap_sc);
        k_mc    = coarse_index(snap_mc);
        k_h     = coarse_index(snap_h);
        sec_val = ({2'b00, k_sc} * 6'd5) + {3'b000, fine_value(snap_sf)};
        min_val = ({2'b00, k_mc} * 6'd5) + {3'b000, fine_value(snap_mf)};
        hr_val  = (k_h == 4'd0) ? 4'd12 : k_h;
        sec_bcd = bcd_split(sec_val);
        min_bcd = bcd_split(min_val);

        err_d = !(fine_legal(snap_sf) && coarse_legal(snap_sc) &&
                  fine_legal(snap_mf) && coarse_legal(snap_mc) &&
                  coarse_legal(snap_h));

        digit_d[0] = sec_bcd[3:0];
        digit_d[1] = sec_bcd[7:4];
        digit_d[2] = min_bcd[3:0];
        digit_d[3] = min_bcd[7:4];
        if (hr_val >= 4'd10) begin
            digit_d[4] = hr_val - 4'd10;
            digit_d[5] = 4'd1;
        end else begin
            digit_d[4] = hr_val;
            digit_d[5] = DIGIT_BLANK;
        end
    end

    logic [3:0] digit_q [6];
    logic       err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) begin
                digit_q[i] <= 4'd0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                digit_q[i] <= digit_d[i];
            end
            err_q <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Scan counter and registered display outputs
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] scan_cnt_q;
    logic [2:0]       digit_idx_q;
    logic [3:0]       cur_digit;
    logic [6:0]       seg_d;
    logic             dp_d;
    logic [6:0]       seg_q;
    logic [5:0]       dig_q;
    logic             dp_q;

    always_comb begin
        cur_digit = digit_q[0];
        case (digit_idx_q)
            3'd0:    cur_digit = digit_q[0];
            3'd1:    cur_digit = digit_q[1];
            3'd2:    cur_digit = digit_q[2];
            3'd3:    cur_digit = digit_q[3];
            3'd4:    cur_digit = digit_q[4];
            3'd5:    cur_digit = digit_q[5];
            default: cur_digit = DIGIT_BLANK;
        endcase
        seg_d = err_q ? SEG_DASH : font(cur_digit);
        dp_d  = ((digit_idx_q == 3'd2) || (digit_idx_q == 3'd4)) && !err_q;
    end

    // dig/seg/dp follow the index one cycle later, so every digit (including
    // digit 0 right after reset) stays enabled for exactly SCAN_DIV cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt_q  <= '0;
            digit_idx_q <= 3'd0;
            seg_q       <= 7'd0;
            dig_q       <= 6'd0;
            dp_q        <= 1'b0;
        end else begin
            if (scan_cnt_q == CNT_LAST) begin
                scan_cnt_q  <= '0;
                digit_idx_q <= (digit_idx_q == 3'd5) ? 3'd0 : digit_idx_q + 3'd1;
            end else begin
                scan_cnt_q <= scan_cnt_q + 1'b1;
            end
            dig_q <= 6'b000001 << digit_idx_q;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign seg = seg_q;
    assign dig = dig_q;
    assign dp  = dp_q;
    assign err = err_q;

endmodule

// File: tb/tb_time_display_scanner.sv
// tb/tb_time_display_scanner.sv - randomized self-checking bench for time_display_scanner

module tb_time_display_scanner;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  sec_fine, mins_fine;
    logic [11:0] sec_coarse, mins_coarse, hours;
    logic [6:0]  seg;
    logic [5:0]  dig;
    logic        dp, err;

    always #5 clk = ~clk;

    time_display_scanner #(.SCAN_DIV(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .sec_fine    (sec_fine),
        .sec_coarse  (sec_coarse),
        .mins_fine   (mins_fine),
        .mins_coarse (mins_coarse),
        .hours       (hours),
        .seg         (seg),
        .dig         (dig),
        .dp          (dp),
        .err         (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: time values computed from the field rules, with the
    // pipeline expressed as a history of inputs seen at each clock edge.
    // ------------------------------------------------------------------
    logic [6:0] font_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                  7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                  7'b1111111, 7'b1101111};

    logic [43:0] inq[$];    // inq[k]   = inputs sampled at edge k since release
    logic [43:0] snapq[$];  // snapq[k] = accepted snapshot after edge k
    int e;                  // edges since reset release

    function automatic logic [3:0] therm(input int n);
        logic [7:0] t;
        t = 8'hF0 >> n;
        return t[3:0];
    endfunction

    function automatic bit fine_ok(input logic [3:0] c);
        return c == therm($countones(c));
    endfunction

    function automatic int coarse_idx(input logic [11:0] c);
        for (int p = 0; p < 12; p++) if (c[p]) return 11 - p;
        return 0;
    endfunction

    function automatic bit snap_bad(input logic [43:0] s);
        return !(fine_ok(s[3:0]) && fine_ok(s[19:16]) && $countones(s[15:4]) == 1 &&
                 $countones(s[31:20]) == 1 && $countones(s[43:32]) == 1);
    endfunction

    function automatic logic [6:0] exp_seg(input logic [43:0] s, input int idx);
        int secs, mins, hrs;
        int d[6];
        if (snap_bad(s)) return 7'b1000000;
        secs = 5 * coarse_idx(s[15:4]) + $countones(s[3:0]);
        mins = 5 * coarse_idx(s[31:20]) + $countones(s[19:16]);
        hrs  = coarse_idx(s[43:32]);
        if (hrs == 0) hrs = 12;
        d = '{secs % 10, secs / 10, mins % 10, mins / 10, hrs % 10, hrs / 10};
        if (idx == 5 && hrs < 10) return 7'b0000000;
        return font_tab[d[idx]];
    endfunction

    function automatic logic [43:0] get_in(input int k);
        return (k < 1) ? 44'd0 : inq[k];
    endfunction

    task automatic model_restart();
        e = 0;
        inq.delete();
        snapq.delete();
        inq.push_back(44'd0);
        snapq.push_back(44'd0);
    endtask

    // mode 0: hold inputs; mode 1: sec_fine alternates 1000/1100 every cycle
    task automatic run_cycles(input int n, input int mode);
        logic [43:0] a, b;
        int idx;
        bit prev_err;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            e++;
            inq.push_back({hours, mins_coarse, mins_fine, sec_coarse, sec_fine});
            a = get_in(e - 2);
            b = get_in(e - 3);
            snapq.push_back((a == b) ? a : snapq[e-1]);
            @(negedge clk);
            idx      = ((e - 1) / D) % 6;
            prev_err = (e >= 2) ? snap_bad(snapq[e-2]) : 1'b0;
            check_eq("err", 32'(err), 32'(snap_bad(snapq[e-1])));
            check_eq("dig", 32'(dig), 32'(6'b000001 << idx));
            check_eq("dp", 32'(dp), 32'((idx == 2 || idx == 4) && !prev_err));
            if (e >= 2) check_eq("seg", 32'(seg), 32'(exp_seg(snapq[e-2], idx)));
            if (mode == 1) sec_fine = (sec_fine == 4'b1000) ? 4'b1100 : 4'b1000;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_seg"}, 32'(seg), 32'd0);
        check_eq({tag, "_dig"}, 32'(dig), 32'd0);
        check_eq({tag, "_dp"},  32'(dp),  32'd0);
        check_eq({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Called at a negedge: asserts reset between edges, then releases it.
    task automatic reset_mid_frame();
        #2 reset = 1'b1;
        #1 check_reset_outputs("rst_async");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_held");
        reset = 1'b0;
        model_restart();
    endtask

    task automatic set_time(input int sc, input int sf, input int mc, input int mf, input int h);
        sec_coarse  = 12'h800 >> sc;
        sec_fine    = therm(sf);
        mins_coarse = 12'h800 >> mc;
        mins_fine   = therm(mf);
        hours       = 12'h800 >> h;
    endtask

    initial begin
        reset = 1'b1;
        set_time(3, 2, 11, 4, 1);          // 01:59:17
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_init");
        reset = 1'b0;
        model_restart();

        run_cycles(40, 0);                 // full frames of the legal pattern
        reset_mid_frame();
        set_time(0, 0, 0, 0, 0);           // 12:00:00
        run_cycles(30, 0);

        sec_coarse = 12'b100000000001;     // illegal one-hot
        run_cycles(30, 0);
        sec_coarse = 12'h800;
        run_cycles(30, 0);

        sec_fine = 4'b1000;
        run_cycles(10, 0);
        run_cycles(50, 1);                 // incoherent input, snapshot must hold
        sec_fine = 4'b1100;
        run_cycles(20, 0);

        // minutes-fine step while the minutes-ones digit is being scanned
        while (((e / D) % 6) != 2) run_cycles(1, 0);
        mins_fine = 4'b1000;
        run_cycles(D * 2, 0);

        for (int seg_n = 0; seg_n < 70; seg_n++) begin
            set_time($urandom_range(0, 11), $urandom_range(0, 4), $urandom_range(0, 11),
                     $urandom_range(0, 4), $urandom_range(0, 11));
            case ($urandom_range(0, 9))
                0: sec_fine    = 4'($urandom);
                1: mins_coarse = 12'($urandom);
                2: hours       = 12'($urandom);
                default: ;
            endcase
            if ($urandom_range(0, 7) == 0) begin
                sec_fine = 4'b1000;
                run_cycles($urandom_range(2, 12), 1);
            end
            run_cycles($urandom_range(1, 20), 0);
            if (seg_n == 35) reset_mid_frame();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
